// File: rtl/hack_pkg.sv
// Shared definitions for the Hack fetch/decode/execute controller.
// Holds the state encoding, IR field positions, widths and the jump-condition helper.
package hack_pkg;

  localparam int WORD_W   = 16;
  localparam int PC_W_DEF = 15;

  localparam int A_BIT   = 12;
  localparam int CTL_HI  = 11;
  localparam int CTL_LO  = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JMP_HI  = 2;
  localparam int JMP_LO  = 0;

  // Destination bits inside IR[5:3] = {A,D,M}
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM_RD = 3'd2,
    EXEC   = 3'd3,
    MEM_WR = 3'd4,
    HALT   = 3'd5
  } state_e;

  function automatic logic jmp_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_pc_reg.sv
// Program counter: async active-low reset, load has priority over increment,
// increment wraps modulo 2^PC_W.
module pc_reg #(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_val_i;
    else if (inc_i) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack controller around an external ALU; owns A, D, M, IR and PC.
// Define HACK_ILL_TRAP_EN to trap C-instructions with IR[14:13] != 2'b11 into HALT.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc,
  input  logic [WORD_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [WORD_W-1:0] alu_x,
  output logic [WORD_W-1:0] alu_y,
  output logic [5:0]        alu_ctl,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic              retire,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] d_q, d_d;
  logic [WORD_W-1:0] m_q, m_d;
  logic [WORD_W-1:0] r_q, r_d;
  logic [PC_W-1:0]   wa_q, wa_d;
  logic              retire_q, retire_d;
  logic              pc_ld, pc_inc;

  pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_ld),
    .inc_i      (pc_inc),
    .load_val_i (a_q[PC_W-1:0]),
    .pc_o       (pc)
  );

`ifdef HACK_ILL_TRAP_EN
  logic ill_q, ill_d;
`endif

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    d_d      = d_q;
    m_d      = m_q;
    r_d      = r_q;
    wa_d     = wa_q;
    retire_d = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
`ifdef HACK_ILL_TRAP_EN
    ill_d    = ill_q;
`endif
    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!ir_q[15]) begin
          a_d      = {1'b0, ir_q[14:0]};
          pc_inc   = 1'b1;
          retire_d = 1'b1;
          state_d  = FETCH;
        end
`ifdef HACK_ILL_TRAP_EN
        else if (ir_q[14:13] != 2'b11) begin
          ill_d   = 1'b1;
          state_d = HALT;
        end
`endif
        else if (ir_q[A_BIT]) state_d = MEM_RD;
        else                  state_d = EXEC;
      end
      MEM_RD: begin
        if (mem_ack) begin
          m_d     = mem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Jump target and write address both use A before this edge's update.
        r_d  = alu_out;
        wa_d = a_q[PC_W-1:0];
        if (ir_q[DEST_A]) a_d = alu_out;
        if (ir_q[DEST_D]) d_d = alu_out;
        if (jmp_taken(ir_q[JMP_HI:JMP_LO], alu_zr, alu_ng)) pc_ld = 1'b1;
        else                                                 pc_inc = 1'b1;
        if (ir_q[DEST_M]) state_d = MEM_WR;
        else begin
          retire_d = 1'b1;
          state_d  = FETCH;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          retire_d = 1'b1;
          state_d  = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      a_q      <= '0;
      d_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      wa_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      d_q      <= d_d;
      m_q      <= m_d;
      r_q      <= r_d;
      wa_q     <= wa_d;
      retire_q <= retire_d;
    end
  end

`ifdef HACK_ILL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_q <= 1'b0;
    else        ill_q <= ill_d;
  end
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  // FETCH is the reset state, so ready is masked while reset is held.
  assign instr_ready = rst_n && (state_q == FETCH);
  assign mem_req     = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_we      = (state_q == MEM_WR);
  assign mem_addr    = (state_q == MEM_WR) ? wa_q : a_q[PC_W-1:0];
  assign mem_wdata   = r_q;
  assign alu_x       = d_q;
  assign alu_y       = ir_q[A_BIT] ? m_q : a_q;
  assign alu_ctl     = ir_q[CTL_HI:CTL_LO];
  assign retire      = retire_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: behavioural Hack ALU plus a ready/ack data memory.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctl;
  logic        alu_zr, alu_ng;
  logic        retire, illegal;

  int errs = 0;
  int checks = 0;

  logic [15:0] mem [0:255];
  int          mem_lat = 1;
  int          mcnt = 0;
  logic [14:0] m_addr0;
  logic        m_we0;
  logic [15:0] m_wd0;
  logic [14:0] last_rd_addr, last_wr_addr;
  logic [15:0] last_wr_data;
  int          n_wr = 0;

  hack_cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, alu_ctl);
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data memory: acks mem_lat cycles after the request appears, checks request stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      mcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      mcnt = 0;
    end else if (mem_req) begin
      if (mcnt == 0) begin
        m_addr0 = mem_addr;
        m_we0   = mem_we;
        m_wd0   = mem_wdata;
      end else begin
        chk("req_addr_stable", 32'(mem_addr), 32'(m_addr0));
        chk("req_we_stable", 32'(mem_we), 32'(m_we0));
        if (mem_we) chk("req_wdata_stable", 32'(mem_wdata), 32'(m_wd0));
      end
      mcnt++;
      if (mcnt > mem_lat) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr[7:0]] = mem_wdata;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
          n_wr++;
        end else begin
          mem_rdata = mem[mem_addr[7:0]];
          last_rd_addr = mem_addr;
        end
      end
    end
  end

  // Issue one instruction; lat counts cycles from the accept cycle up to the edge that retires.
  task automatic run(input logic [15:0] w, output int lat);
    int n;
    lat = -1;
    @(negedge clk);
    chk("retire_one_cycle", 32'(retire), 0);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(instr_ready), 1);
    if (!instr_ready) begin
      instr_valid = 1'b0;
      return;
    end
    @(negedge clk);
    instr = 16'hFFFF;  // held valid while busy; must be ignored
    n = 0;
    while (!retire && n < 100) begin
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b0;
    chk("retire_seen", 32'(retire), 1);
    lat = n + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int wr0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[7] = 16'd3;
    instr = 16'h0000;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    rst_n = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_ready", 32'(instr_ready), 0);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_retire", 32'(retire), 0);
      chk("rst_illegal", 32'(illegal), 0);
    end
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(instr_ready), 1);

    // @5 ; D=A
    run(16'h0005, lat);
    chk("a_lat", lat, 2);
    chk("a_pc", 32'(pc), 1);
    chk("a_val", 32'(alu_y), 5);
    run(16'hEC10, lat);
    chk("c_lat", lat, 3);
    chk("c_pc", 32'(pc), 2);
    chk("c_d", 32'(alu_x), 5);
    chk("c_ctl", 32'(alu_ctl), 32'h30);

    // @100 ; M=D+1 with a 3-cycle ack delay
    run(16'd100, lat);
    mem_lat = 3;
    wr0 = n_wr;
    run(16'hE7C8, lat);
    chk("mw_lat", lat, 7);
    chk("mw_count", n_wr - wr0, 1);
    chk("mw_addr", 32'(last_wr_addr), 100);
    chk("mw_data", 32'(last_wr_data), 6);
    chk("mw_pc", 32'(pc), 4);
    mem_lat = 1;

    // D=5, @10, D;JGT taken
    run(16'd10, lat);
    run(16'hE301, lat);
    chk("jgt_taken_pc", 32'(pc), 10);
    // D=0, @10, D;JGT not taken
    run(16'hEA90, lat);
    run(16'd10, lat);
    run(16'hE301, lat);
    chk("jgt_not_taken_pc", 32'(pc), 13);
    // D=-1, @10, D;JLT taken
    run(16'hEE90, lat);
    chk("d_neg", 32'(alu_x), 32'hFFFF);
    run(16'd10, lat);
    run(16'hE304, lat);
    chk("jlt_taken_pc", 32'(pc), 10);

    // @5 ; D=A ; @10 ; AMD=D+1;JMP -> all targets use the old A
    run(16'd5, lat);
    run(16'hEC10, lat);
    run(16'd10, lat);
    run(16'hE7FF, lat);
    chk("amd_lat", lat, 5);
    chk("amd_pc", 32'(pc), 10);
    chk("amd_wr_addr", 32'(last_wr_addr), 10);
    chk("amd_wr_data", 32'(last_wr_data), 6);
    chk("amd_d", 32'(alu_x), 6);
    chk("amd_a", 32'(alu_y), 6);

    // @7 ; AM=M-1 read-modify-write
    run(16'd7, lat);
    run(16'hFCA8, lat);
    chk("rmw_lat", lat, 7);
    chk("rmw_rd_addr", 32'(last_rd_addr), 7);
    chk("rmw_wr_addr", 32'(last_wr_addr), 7);
    chk("rmw_wr_data", 32'(last_wr_data), 2);
    chk("rmw_mem", 32'(mem[7]), 2);
    run(16'hEC10, lat);
    chk("rmw_a", 32'(alu_x), 2);

    // A=-1 ; 0;JMP truncates target to 0x7FFF ; @0 wraps pc
    run(16'hEEA0, lat);
    chk("a_neg", 32'(alu_y), 32'hFFFF);
    run(16'hEA87, lat);
    chk("trunc_pc", 32'(pc), 32'h7FFF);
    run(16'h0000, lat);
    chk("wrap_pc", 32'(pc), 0);

`ifdef HACK_ILL_TRAP_EN
    @(negedge clk);
    instr = 16'h8000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = 16'hFFFF;
    repeat (4) begin
      @(negedge clk);
      chk("trap_illegal", 32'(illegal), 1);
      chk("trap_ready", 32'(instr_ready), 0);
      chk("trap_pc", 32'(pc), 0);
      chk("trap_retire", 32'(retire), 0);
      chk("trap_req", 32'(mem_req), 0);
    end
    instr_valid = 1'b0;
`else
    run(16'h8000, lat);
    chk("noill_lat", lat, 3);
    chk("noill_pc", 32'(pc), 1);
    chk("noill_illegal", 32'(illegal), 0);
`endif

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_illegal", 32'(illegal), 0);
    rst_n = 1'b1;
    #1 chk("rst2_ready", 32'(instr_ready), 1);
    chk("rst2_pc", 32'(pc), 0);

    // @7 ; AM=M-1 with a long write wait, aborted by reset
    run(16'd7, lat);
    mem_lat = 20;
    @(negedge clk);
    instr = 16'hFCA8;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = 16'hFFFF;
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b0;
    chk("abort_wr_pending", 32'(mem_req && mem_we), 1);
    chk("abort_wr_addr", 32'(mem_addr), 7);
    chk("abort_wr_data", 32'(mem_wdata), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 0);
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_pc", 32'(pc), 0);
    chk("abort_ready", 32'(instr_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_write", 32'(mem[7]), 2);
    chk("abort_idle_req", 32'(mem_req), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
